// File: rtl/online_sd2bin_conv_pkg.sv
// online_sd2bin_conv_pkg: shared definitions for the SD-to-binary on-the-fly converter.
//   SD_POS / SD_NEG : {p,n} digit encodings for +1 / -1 (2'b00 and 2'b11 both mean 0)
//   state_t         : converter FSM states
//   sd_val()        : maps a 2-bit {p,n} digit to its signed value
package online_sd2bin_conv_pkg;

    localparam logic [1:0] SD_POS = 2'b10;
    localparam logic [1:0] SD_NEG = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic signed [1:0] sd_val(input logic [1:0] d);
        case (d)
            SD_POS:  return 2'sb01;
            SD_NEG:  return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/online_sd2bin_conv_if.sv
// online_sd2bin_conv_if: ready/valid input and output channels of the converter.
//   in_valid/in_ready/sd_in     : SD word from upstream (2*ND bits)
//   out_valid/out_ready/bin_out : two's complement result (OUT_W bits)
//   master : upstream/consumer side, slave : converter side
interface online_sd2bin_conv_if
    import online_sd2bin_conv_pkg::*;
#(
    parameter int unsigned ND    = 10,
    parameter int unsigned OUT_W = 11
) ();

    logic              in_valid;
    logic              in_ready;
    logic [2*ND-1:0]   sd_in;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  bin_out;

    modport master (
        output in_valid, sd_in, out_ready,
        input  in_ready, out_valid, bin_out
    );

    modport slave (
        input  in_valid, sd_in, out_ready,
        output in_ready, out_valid, bin_out
    );

endinterface

// File: rtl/online_sd2bin_conv_otfc_step.sv
// otfc_step: one-digit combinational on-the-fly conversion update.
//   digit        : {p,n} SD digit
//   q_in, qm_in  : current Q and QM (QM = Q - 1 ulp)
//   q_out, qm_out: Q and QM after appending the digit
module otfc_step
    import online_sd2bin_conv_pkg::*;
#(
    parameter int unsigned W = 11
) (
    input  logic [1:0]   digit,
    input  logic [W-1:0] q_in,
    input  logic [W-1:0] qm_in,
    output logic [W-1:0] q_out,
    output logic [W-1:0] qm_out
);

    always_comb begin
        // zero digit by default
        q_out  = {q_in[W-2:0], 1'b0};
        qm_out = {qm_in[W-2:0], 1'b1};
        case (sd_val(digit))
            2'sb01: begin
                q_out  = {q_in[W-2:0], 1'b1};
                qm_out = {q_in[W-2:0], 1'b0};
            end
            2'sb11: begin
                q_out  = {qm_in[W-2:0], 1'b1};
                qm_out = {qm_in[W-2:0], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/online_sd2bin_conv.sv
// online_sd2bin_conv: digit-serial radix-2 SD to two's complement converter (OTFC).
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : online_sd2bin_conv_if.slave (sd_in in, bin_out out, ready/valid both sides)
//   busy     : high while digits are being consumed
// Macro ONLINE_SD2BIN_ROUND_EN: when OUT_W < ND+1, round half-up with positive
// saturation (one extra registered cycle); otherwise the result is truncated.
module online_sd2bin_conv
    import online_sd2bin_conv_pkg::*;
#(
    parameter int unsigned ND    = 10,
    parameter int unsigned DPC   = 1,
    parameter int unsigned OUT_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    online_sd2bin_conv_if.slave   bus,
    output logic                  busy
);

    localparam int unsigned W  = ND + 1;
    localparam int unsigned NG = ND / DPC;
    localparam int unsigned CW = (NG > 1) ? $clog2(NG) : 1;
`ifdef ONLINE_SD2BIN_ROUND_EN
    localparam bit RND = (OUT_W < W);
`else
    localparam bit RND = 1'b0;
`endif

    if (DPC < 1 || DPC > 2 || (ND % DPC) != 0 || OUT_W < 2 || OUT_W > W) begin : g_bad_cfg
        $error("online_sd2bin_conv: illegal ND/DPC/OUT_W combination");
    end

    state_t              state;
    logic [2*ND-1:0]     sr;
    logic [W-1:0]        q_r;
    logic [W-1:0]        qm_r;
    logic [CW-1:0]       cnt;
    logic                stg;
    logic [OUT_W-1:0]    rnd_r;
    logic [OUT_W-1:0]    fin_c;
    logic [DPC:0][W-1:0] q_ch;
    logic [DPC:0][W-1:0] qm_ch;

    // DPC digit updates chained MSD-first within one cycle
    assign q_ch[0]  = q_r;
    assign qm_ch[0] = qm_r;
    for (genvar j = 0; j < DPC; j++) begin : g_step
        otfc_step #(.W(W)) u_step (
            .digit  (sr[2*ND-1-2*j -: 2]),
            .q_in   (q_ch[j]),
            .qm_in  (qm_ch[j]),
            .q_out  (q_ch[j+1]),
            .qm_out (qm_ch[j+1])
        );
    end

    // Result width reduction
    if (OUT_W == W) begin : g_full
        assign fin_c = q_r;
    end else if (RND) begin : g_round
        logic [OUT_W:0] sum_c;
        // sign-extended add of the first dropped bit; only a positive value can overflow
        assign sum_c = {q_r[ND], q_r[ND -: OUT_W]} + (OUT_W+1)'(q_r[ND-OUT_W]);
        assign fin_c = (sum_c[OUT_W] != sum_c[OUT_W-1]) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                          : sum_c[OUT_W-1:0];
        if (ND > OUT_W) begin : g_lo
            logic unused_lo;
            assign unused_lo = ^q_r[ND-OUT_W-1:0];
        end
    end else begin : g_trunc
        logic unused_lo;
        assign fin_c     = q_r[ND -: OUT_W];
        assign unused_lo = ^q_r[ND-OUT_W:0];
    end

    // FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.bin_out   <= '0;
            busy          <= 1'b0;
            sr            <= '0;
            q_r           <= '0;
            qm_r          <= '0;
            cnt           <= '0;
            stg           <= 1'b0;
            rnd_r         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state        <= ST_CONV;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        sr           <= bus.sd_in;
                        q_r          <= '0;
                        qm_r         <= '1;
                        cnt          <= CW'(NG - 1);
                        stg          <= 1'b0;
                    end
                end
                ST_CONV: begin
                    q_r  <= q_ch[DPC];
                    qm_r <= qm_ch[DPC];
                    sr   <= sr << (2 * DPC);
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(0)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (bus.out_valid) begin
                        if (bus.out_ready) begin
                            state         <= ST_IDLE;
                            bus.out_valid <= 1'b0;
                            bus.in_ready  <= 1'b1;
                        end
                    end else if (!RND || stg) begin
                        bus.bin_out   <= RND ? rnd_r : fin_c;
                        bus.out_valid <= 1'b1;
                    end else begin
                        rnd_r <= fin_c;
                        stg   <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_online_sd2bin_conv.sv
// tb_online_sd2bin_conv: randomized self-checking bench for online_sd2bin_conv.
// Three instances: A (ND=10,DPC=1,OUT_W=11), B (DPC=2), C (OUT_W=4).
// Reference value is the arithmetic sum of digit weights, then scaled to OUT_W.
module tb_online_sd2bin_conv;
    import online_sd2bin_conv_pkg::*;

    localparam int unsigned ND = 10;

    logic clk = 1'b0;
    logic rst;
    logic busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    online_sd2bin_conv_if #(.ND(ND), .OUT_W(11)) bus_a ();
    online_sd2bin_conv_if #(.ND(ND), .OUT_W(11)) bus_b ();
    online_sd2bin_conv_if #(.ND(ND), .OUT_W(4))  bus_c ();

    online_sd2bin_conv #(.ND(ND), .DPC(1), .OUT_W(11)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave), .busy(busy_a));
    online_sd2bin_conv #(.ND(ND), .DPC(2), .OUT_W(11)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave), .busy(busy_b));
    online_sd2bin_conv #(.ND(ND), .DPC(1), .OUT_W(4))  dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave), .busy(busy_c));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int u, input logic v, input logic [2*ND-1:0] sd, input logic ordy);
        case (u)
            0: begin bus_a.in_valid = v; bus_a.sd_in = sd; bus_a.out_ready = ordy; end
            1: begin bus_b.in_valid = v; bus_b.sd_in = sd; bus_b.out_ready = ordy; end
            default: begin bus_c.in_valid = v; bus_c.sd_in = sd; bus_c.out_ready = ordy; end
        endcase
    endtask

    function automatic int ov(input int u);
        return (u == 0) ? int'(bus_a.out_valid) : (u == 1) ? int'(bus_b.out_valid) : int'(bus_c.out_valid);
    endfunction

    function automatic int ir(input int u);
        return (u == 0) ? int'(bus_a.in_ready) : (u == 1) ? int'(bus_b.in_ready) : int'(bus_c.in_ready);
    endfunction

    function automatic int bz(input int u);
        return (u == 0) ? int'(busy_a) : (u == 1) ? int'(busy_b) : int'(busy_c);
    endfunction

    function automatic int bo(input int u);
        int v;
        case (u)
            0:       v = int'($signed(bus_a.bin_out));
            1:       v = int'($signed(bus_b.bin_out));
            default: v = int'($signed(bus_c.bin_out));
        endcase
        return v;
    endfunction

    function automatic int out_w(input int u);
        return (u == 2) ? 4 : 11;
    endfunction

    // Integer value of the SD word, LSD weight 1
    function automatic int sd_value(input logic [2*ND-1:0] sd);
        int r = 0;
        for (int i = 0; i < ND; i++) begin
            logic [1:0] d;
            d = sd[2*i +: 2];
            if (d == 2'b10)      r += (1 << i);
            else if (d == 2'b01) r -= (1 << i);
        end
        return r;
    endfunction

    function automatic int expect_out(input int u, input logic [2*ND-1:0] sd);
        int r, k, m, y;
        r = sd_value(sd);
        k = ND + 1 - out_w(u);
        if (k == 0) return r;
        m = (1 << (out_w(u) - 1)) - 1;
`ifdef ONLINE_SD2BIN_ROUND_EN
        y = (r + (1 << (k - 1))) >>> k;
        if (y > m) y = m;
`else
        y = r >>> k;
`endif
        return y;
    endfunction

    function automatic int expect_lat(input int u);
        int l;
        l = ND / ((u == 1) ? 2 : 1) + 1;
`ifdef ONLINE_SD2BIN_ROUND_EN
        if (out_w(u) < ND + 1) l++;
`endif
        return l;
    endfunction

    task automatic run_word(input int u, input logic [2*ND-1:0] sd, input int hold);
        int cyc;
        int exp;
        exp = expect_out(u, sd);
        cyc = 0;
        while (ir(u) == 0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check("in_ready_idle", ir(u), 1);
        drive(u, 1'b1, sd, 1'b0);
        @(posedge clk); #1;
        drive(u, 1'b0, 20'($urandom), 1'b0);
        check("busy_conv", bz(u), 1);
        cyc = 0;
        while (ov(u) == 0 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("latency", cyc, expect_lat(u));
        check("result", bo(u), exp);
        for (int h = 0; h < hold; h++) begin
            drive(u, 1'b1, 20'($urandom), 1'b0);
            @(posedge clk); #1;
            check("hold_value", bo(u), exp);
            check("hold_in_ready", ir(u), 0);
            check("hold_out_valid", ov(u), 1);
        end
        drive(u, 1'b0, 20'($urandom), 1'b1);
        @(posedge clk); #1;
        drive(u, 1'b0, 20'($urandom), 1'b0);
        check("out_valid_drop", ov(u), 0);
        check("in_ready_back", ir(u), 1);
    endtask

    function automatic logic [2*ND-1:0] rand_word();
        logic [2*ND-1:0] w;
        for (int i = 0; i < ND; i++) w[2*i +: 2] = 2'($urandom_range(0, 3));
        return w;
    endfunction

    logic [2*ND-1:0] directed [7];
    int saw_valid;

    initial begin
        directed[0] = 20'h00000;
        directed[1] = 20'hFFFFF;
        directed[2] = 20'h80000;
        directed[3] = 20'h40000;
        directed[4] = 20'h99999;
        directed[5] = 20'h55555;
        directed[6] = 20'hAAAAA;

        rst = 1'b1;
        for (int u = 0; u < 3; u++) drive(u, 1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check("rst_in_ready", ir(u), 1);
            check("rst_out_valid", ov(u), 0);
            check("rst_busy", bz(u), 0);
            check("rst_bin_out", bo(u), 0);
        end
        rst = 1'b0;

        // Directed patterns on every instance, with a long out_ready stall on A
        for (int u = 0; u < 3; u++)
            for (int i = 0; i < 7; i++)
                run_word(u, directed[i], (u == 0 && i == 4) ? 5 : 0);

        // Reset in the middle of a conversion discards the word
        drive(0, 1'b1, 20'h99999, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", bz(0), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_in_ready", ir(0), 1);
        check("mid_rst_busy", bz(0), 0);
        saw_valid = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (ov(0) != 0) saw_valid = 1;
        end
        check("mid_rst_no_output", saw_valid, 0);
        run_word(0, 20'h80000, 0);

        // Randomized words
        for (int n = 0; n < 25; n++)
            for (int u = 0; u < 3; u++)
                run_word(u, rand_word(), int'($urandom_range(0, 2)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
